fifo_stream_reader: RTL and testbench

//  Drains a synch FIFO (1-cycle read latency) and presents its words as a valid/ready stream.

---
 rtl/fifo_stream_reader.sv | 143 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// fifo_stream_reader : drains a 1-cycle-latency FIFO into a framed valid/ready stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_rddata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_sent
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      sent_q;
  logic [DATA_WIDTH-1:0] data0, data1;
  logic                  last0, last1;
  logic [1:0]            count;
  logic                  inflight;
  logic                  inflight_last;
  logic                  done_q;

  logic                  pop;
  logic [2:0]            occ_after;
  logic                  start_ok;
  logic                  finish;
  logic                  rden;

  // Entry 0 is always the head; entry 1 only holds a word when count == 2.
  always_comb begin
    pop       = (count != 2'd0) && out_ready;
    occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    start_ok  = (state == IDLE) && start && (frame_len != '0);
    finish    = (state == STREAM) && pop && last0;
    rden      = (state == STREAM) && !fifo_empty && (issued < len_q) && (occ_after < 3'd2);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = STREAM;
      STREAM:  if (finish)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      issued        <= '0;
      sent_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_next;
      done_q        <= finish;
      inflight      <= rden;
      inflight_last <= rden && ((issued + LEN_W'(1)) == len_q);
      if (start_ok) begin
        len_q  <= frame_len;
        issued <= '0;
        sent_q <= '0;
      end else begin
        if (rden) issued <= issued + LEN_W'(1);
        if (pop)  sent_q <= sent_q + LEN_W'(1);
      end
    end
  end

  // Returning read data lands at the tail; a simultaneous pop shifts entry 1 forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      count <= 2'd0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= fifo_rddata;
            last0 <= inflight_last;
          end else begin
            data1 <= fifo_rddata;
            last1 <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= fifo_rddata;
            last0 <= inflight_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= fifo_rddata;
            last1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rden  = rden;
  assign out_valid  = (count != 2'd0);
  assign out_data   = data0;
  assign out_last   = last0;
  assign busy       = (state == STREAM);
  assign done       = done_q;
  assign words_sent = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// tb_fifo_stream_reader : directed self-checking bench with a behavioural FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] fifo_rddata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];
  int          rd = 0;
  int          wr = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd == wr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rddata <= mem[rd];
      rd          <= rd + 1;
    end
  end

  fifo_stream_reader #(.DATA_WIDTH(32), .LEN_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .words_sent  (words_sent)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr] = base + 32'(i);
      wr      = wr + 1;
    end
  endtask

  // Accepts n words starting at the current negedge, then checks the done pulse.
  task automatic collect(input string tag, input logic [31:0] base, input int n);
    int k = 0;
    for (int c = 0; c < 40 && k < n; c++) begin
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, out_data, base + 32'(k));
        chk({tag, "_last"}, out_last, (k == n - 1));
        k++;
      end
      step();
    end
    chk({tag, "_count"}, k, n);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int rcnt;
    int bad;

    rst = 1'b1; start = 1'b0; frame_len = '0; out_ready = 1'b0;
    push_words(32'hA0, 4);

    // Reset state with a non-empty FIFO
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data,  32'h0);
    chk("rst_rden",  fifo_rden, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_sent",  words_sent, 16'h0);
    rst = 1'b0;
    step();
    chk("idle_rden", fifo_rden, 1'b0);
    chk("idle_last", out_last,  1'b0);

    // len=4, ready=1: back-to-back reads and words, first word two edges after start
    out_ready = 1'b1; start = 1'b1; frame_len = 16'd4;
    step();
    start = 1'b0;
    chk("t2_busy", busy, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t2_rden_c%0d", c),  fifo_rden, (c <= 4));
      chk($sformatf("t2_valid_c%0d", c), out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk($sformatf("t2_data_c%0d", c), out_data, 32'hA0 + 32'(c - 3));
        chk($sformatf("t2_last_c%0d", c), out_last, (c == 6));
      end
      chk($sformatf("t2_done_c%0d", c), done, (c == 7));
      if (c < 7) step();
    end
    chk("t2_sent", words_sent, 16'd4);
    chk("t2_busy_end", busy, 1'b0);
    step();
    chk("t2_done_once", done, 1'b0);

    // len=6 with backpressure: only two reads outstanding, head held
    push_words(32'hB0, 6);
    out_ready = 1'b0; start = 1'b1; frame_len = 16'd6;
    step();
    start = 1'b0;
    rcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (fifo_rden) rcnt++;
      step();
    end
    chk("t3_rden_pulses", rcnt, 2);
    chk("t3_hold_valid", out_valid, 1'b1);
    chk("t3_hold_data",  out_data,  32'hB0);
    chk("t3_hold_sent",  words_sent, 16'd0);
    out_ready = 1'b1;
    collect("t3", 32'hB0, 6);
    chk("t3_sent", words_sent, 16'd6);

    // FIFO runs dry after two of five words, then refills
    push_words(32'hC0, 2);
    start = 1'b1; frame_len = 16'd5;
    step();
    start = 1'b0;
    rcnt = 0; bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (fifo_rden) rcnt++;
      if (fifo_rden && fifo_empty) bad++;
      step();
    end
    chk("t4_rden_pulses", rcnt, 2);
    chk("t4_rden_empty",  bad, 0);
    chk("t4_valid_drop",  out_valid, 1'b0);
    chk("t4_busy",        busy, 1'b1);
    chk("t4_sent_mid",    words_sent, 16'd2);
    push_words(32'hC2, 3);
    collect("t4", 32'hC2, 3);
    chk("t4_sent", words_sent, 16'd5);

    // frame_len=0 is ignored; a start while busy is ignored
    push_words(32'hD0, 2);
    start = 1'b1; frame_len = 16'd0;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_zero_busy_c%0d", c), busy, 1'b0);
      chk($sformatf("t5_zero_rden_c%0d", c), fifo_rden, 1'b0);
      step();
    end
    start = 1'b1; frame_len = 16'd2;
    step();
    frame_len = 16'd5;
    step();
    start = 1'b0;
    collect("t5", 32'hD0, 2);
    chk("t5_sent", words_sent, 16'd2);
    step();
    chk("t5_no_restart_busy", busy, 1'b0);
    chk("t5_no_restart_rden", fifo_rden, 1'b0);

    // Reset mid-frame discards buffered words; next frame takes the following FIFO words
    push_words(32'h60, 4);
    out_ready = 1'b0; start = 1'b1; frame_len = 16'd4;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("t6_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_data",  out_data,  32'h0);
    chk("t6_rst_busy",  busy,      1'b0);
    chk("t6_rst_rden",  fifo_rden, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    out_ready = 1'b1; start = 1'b1; frame_len = 16'd2;
    step();
    start = 1'b0;
    collect("t6", 32'h62, 2);
    chk("t6_sent", words_sent, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
